// File: rtl/stream_demux_n.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_n
// Purpose  : Registered 1:N valid/ready stream demultiplexer that routes by
//            explicit select or by an internal round-robin pointer.
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux_n #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         sel,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic [SEL_W-1:0]         rr_ptr,
  output logic                     err,
  output logic [7:0]               drop_cnt
);

  localparam logic [SEL_W:0]   c_n_ch    = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(N_CH-1);
  localparam int               c_pad_w   = 2**SEL_W;

  logic [N_CH-1:0]    r_valid;
  logic [DATA_W-1:0]  r_data [N_CH];
  logic [SEL_W-1:0]   r_rr_ptr;
  logic               r_err;
  logic [7:0]         r_drop_cnt;

  logic [SEL_W-1:0]   w_tgt;
  logic               w_illegal;
  logic               w_accept;
  logic [c_pad_w-1:0] w_vld_pad;
  logic [c_pad_w-1:0] w_rdy_pad;
  logic [N_CH-1:0]    w_load;

  // Pad the per-channel flags to the full select range so an out-of-range
  // select indexes defined zeros instead of running off the vector.
  always_comb begin
    w_vld_pad = '0;
    w_rdy_pad = '0;
    w_vld_pad[N_CH-1:0] = r_valid;
    w_rdy_pad[N_CH-1:0] = out_ready;
  end

  assign w_tgt     = mode ? r_rr_ptr : sel;
  assign w_illegal = !mode && ({1'b0, sel} >= c_n_ch);
  assign in_ready  = w_illegal | ~w_vld_pad[w_tgt] | w_rdy_pad[w_tgt];
  assign w_accept  = in_valid & in_ready;

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign w_load[k] = w_accept & ~w_illegal & (w_tgt == SEL_W'(k));

      // A load on the draining edge wins, giving back-to-back throughput.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid[k] <= 1'b0;
          r_data[k]  <= '0;
        end else if (w_load[k]) begin
          r_valid[k] <= 1'b1;
          r_data[k]  <= in_data;
        end else if (out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end

      assign out_data[k*DATA_W +: DATA_W] = r_data[k];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept && mode)
        r_rr_ptr <= (r_rr_ptr == c_last_ch) ? '0 : r_rr_ptr + 1'b1;
      r_err <= w_accept & w_illegal;
      if (w_accept && w_illegal && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign out_valid = r_valid;
  assign rr_ptr    = r_rr_ptr;
  assign err       = r_err;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Registered 1:N demultiplexer for a valid/ready stream; generalises the team's 1:2 combinational demux.
- Routes each accepted input word to one of N_CH output channels.
- Channel is chosen by an explicit select (mode 0) or by an internal round-robin pointer (mode 1).
- Each channel has a one-word output holding register with its own handshake. Sits between a single producer and N independent consumers.

Parameters:
DATA_W, 8, width of data word
N_CH, 4, number of output channels (2..16)
SEL_W, 2, select width; must equal clog2(N_CH)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
mode  input  1  0 = select-routed, 1 = round-robin
in_valid  input  1  input word valid
in_ready  output  1  input can be accepted this cycle
in_data  input  DATA_W  input word
sel  input  SEL_W  target channel (mode 0 only)
out_valid  output  N_CH  per-channel output valid, bit k = channel k
out_ready  input  N_CH  per-channel consumer ready
out_data  output  N_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
rr_ptr  output  SEL_W  current round-robin target
err  output  1  one-cycle pulse: illegal select word dropped
drop_cnt  output  8  saturating count of dropped words

Behaviour:
- Reset (async assert, sync-safe deassert by user): out_valid=0, all out_data=0, rr_ptr=0, err=0, drop_cnt=0.
- Target channel tgt:
  - mode 0: tgt = sel.
  - mode 1: tgt = rr_ptr; sel is ignored.
- Illegal select: mode 0 with sel >= N_CH.
  - in_ready=1; word is consumed and dropped.
  - err=1 on the next cycle only.
  - drop_cnt increments, saturating at 255.
  - No channel is written.
- Legal target:
  - in_ready = !out_valid[tgt] | out_ready[tgt].
  - This is combinational from out_valid, out_ready, mode, sel and rr_ptr. There is no path from in_valid to in_ready.
- Accept condition: in_valid & in_ready.
  - On accept: out_data[tgt] <= in_data and out_valid[tgt] <= 1 at the next edge.
  - Latency is 1 cycle from accept to out_valid.
- Channel drain: out_valid[k] & out_ready[k] clears out_valid[k] at the next edge, unless the same edge loads channel k.
  - Simultaneous drain and load on channel k: out_valid[k] stays 1 and out_data[k] takes the new word. Full throughput of one word per cycle.
- Hold: when out_valid[k]=1 and out_ready[k]=0, out_data[k] must not change.
- Non-target channels are unaffected by input activity. Any number of channels may drain in the same cycle.
- out_data[k] keeps its last value after drain; it is not cleared.
- Round-robin pointer:
  - Advances only on an accepted word in mode 1: rr_ptr <= (rr_ptr == N_CH-1) ? 0 : rr_ptr+1.
  - Holds in mode 0 and when no word is accepted.
  - A blocked target stalls the input; it never skips to another channel.
- Mode change: takes effect combinationally in the same cycle. rr_ptr is not reset by a mode change.
- err is registered and is 0 in every cycle that does not follow an illegal drop.
- Reset mid-operation: all pending words are lost and outputs return to reset values immediately, without waiting for a clock edge.
- Non-power-of-two N_CH: illegal-select handling applies in mode 0; rr_ptr wraps at N_CH-1.

Test Plan:
1. Reset then mode 0, N_CH=4, out_ready=4'b1111. Send 0xA1 sel=2 -> next cycle out_valid=4'b0100, channel 2 data=0xA1; cleared the cycle after; rr_ptr stays 0.
2. Backpressure, mode 0, out_ready[1]=0. Send 0x11 then 0x22, both sel=1 -> 0x11 is held in channel 1 and in_ready=0 for the second word. Raise out_ready[1] -> 0x22 is accepted in that same cycle and channel 1 shows 0x22 on the next cycle, with no bubble.
3. Round-robin, mode 1, all ready. Send 6 back-to-back words 0x01..0x06 -> they appear on channels 0,1,2,3,0,1 at one per cycle; rr_ptr ends at 2.
4. Round-robin stall, mode 1, rr_ptr=3, channel 3 full, out_ready[3]=0 -> in_ready=0 and rr_ptr holds at 3; channel 0 is not written. Release out_ready[3] -> the word lands in channel 3 and rr_ptr becomes 0.
5. Illegal select, N_CH=3 build, mode 0. Send 0x55 sel=3 -> in_ready=1, err pulses for one cycle, drop_cnt=1, out_valid unchanged. Send 300 illegal words -> drop_cnt saturates at 255.
6. Async reset: assert rst mid-cycle while channels 0 and 2 are valid -> out_valid=0, rr_ptr=0, drop_cnt=0 immediately, before the next clk edge.
